sum_window_acc: RTL

SUM_WINDOW_ACC -- requirements
Module: sum_window_acc

---
 rtl/sum_window_acc.sv | 101 ++++++++++
 1 files changed

// File: rtl/sum_window_acc.sv
// sum_window_acc: collects clamped 9-input bit-sums into windows of WINDOW
// samples (or shorter, on flush). Each result reports the saturated total,
// the largest sample, the sample count and an out-of-range flag. The result
// is held until downstream takes it.
module sum_window_acc #(
   parameter int WINDOW = 16,
   parameter int ACC_W  = 8,
   parameter int CNT_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       in_sum,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [3:0]       out_max,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovr
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WINDOW);
   localparam logic [ACC_W-1:0] SAT_MAX = '1;

   state_t           state_q;
   logic [ACC_W-1:0] total_q;
   logic [3:0]       max_q;
   logic [CNT_W-1:0] count_q;
   logic             ovr_q;

   logic             accept;
   logic             over;
   logic [3:0]       clamped;
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] total_d;
   logic [3:0]       max_d;
   logic [CNT_W-1:0] count_d;

   // Sample datapath: clamp the incoming value and form the next window totals.
   always_comb begin
      accept  = in_valid && (state_q == ACCUM);
      over    = (in_sum > 4'd9);
      clamped = over ? 4'd9 : in_sum;
      // one spare bit catches the carry so the total saturates instead of wrapping
      sum_ext = {1'b0, total_q} + {{(ACC_W-3){1'b0}}, clamped};
      total_d = sum_ext[ACC_W] ? SAT_MAX : sum_ext[ACC_W-1:0];
      max_d   = (clamped > max_q) ? clamped : max_q;
      count_d = count_q + 1'b1;
   end

   // Window FSM and accumulator registers; reset and handshake clear everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         total_q <= '0;
         max_q   <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  total_q <= total_d;
                  max_q   <= max_d;
                  count_q <= count_d;
                  ovr_q   <= ovr_q | over;
                  // a flush alongside the last sample still closes only once
                  if (count_d == WIN_C || flush) state_q <= HOLD;
               end else if (flush && count_q != '0) begin
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q <= ACCUM;
                  total_q <= '0;
                  max_q   <= '0;
                  count_q <= '0;
                  ovr_q   <= 1'b0;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   // Result is only visible while held; the accumulating window reads as zero.
   always_comb begin
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == HOLD);
      out_total = out_valid ? total_q : '0;
      out_max   = out_valid ? max_q   : '0;
      out_count = out_valid ? count_q : '0;
      out_ovr   = out_valid ? ovr_q   : 1'b0;
   end

endmodule
